// File: rtl/lcd_nibble_sequencer.sv
// Spartan-3E character LCD sequencer (4-bit mode): power-on init, config bytes, then CPU byte writes.
// Optional 2-entry request FIFO enabled by defining LCD_BYTE_FIFO_EN.
module lcd_nibble_sequencer #(
  parameter int unsigned T_POWERON = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_GAP     = 50,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EPULSE  = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       ready,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_data,
  output logic       sf_ce0
);

  typedef enum logic [2:0] {PWR_WAIT, SETUP, EHIGH, HOLD, WAIT, IDLE} state_t;

  // Counter reload value for an N-cycle delay; zero is stretched to one cycle.
  function automatic logic [19:0] dly(input int unsigned n);
    return (n == 0) ? 20'd0 : 20'(n - 1);
  endfunction

  localparam logic [19:0] D_POWERON = dly(T_POWERON);
  localparam logic [19:0] D_INIT1   = dly(T_INIT1);
  localparam logic [19:0] D_INIT2   = dly(T_INIT2);
  localparam logic [19:0] D_CMD     = dly(T_CMD);
  localparam logic [19:0] D_GAP     = dly(T_GAP);
  localparam logic [19:0] D_CLEAR   = dly(T_CLEAR);
  localparam logic [19:0] D_SETUP   = dly(T_SETUP);
  localparam logic [19:0] D_EPULSE  = dly(T_EPULSE);

  state_t      state_reg, state_next;
  logic [19:0] cnt_reg, cnt_next;
  logic [3:0]  step_reg, step_next;
  logic        hold_rs_reg, hold_rs_next;
  logic [7:0]  hold_data_reg, hold_data_next;
  logic        lcd_e_reg, lcd_rs_reg, init_done_reg;
  logic [3:0]  lcd_data_reg;
  logic [3:0]  cur_nib;
  logic [19:0] cur_post;
  logic        cur_rs;
  logic        start, start_rs;
  logic [7:0]  start_data;

  // Steps 0-3 are init nibbles, 4-11 the config bytes, 12-13 the CPU byte.
  always_comb begin
    cur_nib  = 4'h0;
    cur_post = D_CMD;
    case (step_reg)
      4'd0:  begin cur_nib = 4'h3; cur_post = D_INIT1; end
      4'd1:  begin cur_nib = 4'h3; cur_post = D_INIT2; end
      4'd2:  begin cur_nib = 4'h3; cur_post = D_CMD;   end
      4'd3:  begin cur_nib = 4'h2; cur_post = D_CMD;   end
      4'd4:  begin cur_nib = 4'h2; cur_post = D_GAP;   end
      4'd5:  begin cur_nib = 4'h8; cur_post = D_CMD;   end
      4'd6:  begin cur_nib = 4'h0; cur_post = D_GAP;   end
      4'd7:  begin cur_nib = 4'h6; cur_post = D_CMD;   end
      4'd8:  begin cur_nib = 4'h0; cur_post = D_GAP;   end
      4'd9:  begin cur_nib = 4'hC; cur_post = D_CMD;   end
      4'd10: begin cur_nib = 4'h0; cur_post = D_GAP;   end
      4'd11: begin cur_nib = 4'h1; cur_post = D_CLEAR; end
      4'd12: begin cur_nib = hold_data_reg[7:4]; cur_post = D_GAP; end
      4'd13: begin
        cur_nib  = hold_data_reg[3:0];
        cur_post = (!hold_rs_reg && (hold_data_reg == 8'h01 || hold_data_reg == 8'h02))
                   ? D_CLEAR : D_CMD;
      end
      default: ;
    endcase
  end

  assign cur_rs = (step_reg >= 4'd12) ? hold_rs_reg : 1'b0;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = (cnt_reg != 20'd0) ? cnt_reg - 20'd1 : 20'd0;
    step_next      = step_reg;
    hold_rs_next   = hold_rs_reg;
    hold_data_next = hold_data_reg;
    case (state_reg)
      PWR_WAIT: if (cnt_reg == 20'd0) begin state_next = SETUP; cnt_next = D_SETUP; end
      SETUP:    if (cnt_reg == 20'd0) begin state_next = EHIGH; cnt_next = D_EPULSE; end
      EHIGH:    if (cnt_reg == 20'd0) begin state_next = HOLD;  cnt_next = 20'd0; end
      HOLD: begin
        state_next = WAIT;
        cnt_next   = cur_post;
      end
      WAIT: if (cnt_reg == 20'd0) begin
        if (step_reg == 4'd11 || step_reg == 4'd13) begin
          state_next = IDLE;
          step_next  = 4'd12;
        end else begin
          state_next = SETUP;
          cnt_next   = D_SETUP;
          step_next  = step_reg + 4'd1;
        end
      end
      IDLE: if (start) begin
        state_next     = SETUP;
        cnt_next       = D_SETUP;
        step_next      = 4'd12;
        hold_rs_next   = start_rs;
        hold_data_next = start_data;
      end
      default: state_next = PWR_WAIT;
    endcase
  end

  // LCD pins are registered off the current state, so E lags the state by one clock
  // and data/RS are already settled T_SETUP cycles before E rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= PWR_WAIT;
      cnt_reg       <= D_POWERON;
      step_reg      <= 4'd0;
      hold_rs_reg   <= 1'b0;
      hold_data_reg <= 8'h00;
      lcd_e_reg     <= 1'b0;
      lcd_rs_reg    <= 1'b0;
      lcd_data_reg  <= 4'h0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      step_reg      <= step_next;
      hold_rs_reg   <= hold_rs_next;
      hold_data_reg <= hold_data_next;
      lcd_e_reg     <= (state_reg == EHIGH);
      if (state_reg == SETUP) begin
        lcd_data_reg <= cur_nib;
        lcd_rs_reg   <= cur_rs;
      end
      if (state_reg == IDLE) init_done_reg <= 1'b1;
    end
  end

`ifdef LCD_BYTE_FIFO_EN
  logic [8:0] fifo_mem [2];
  logic       wr_ptr_reg, rd_ptr_reg, alive_reg;
  logic [1:0] fifo_cnt_reg;
  logic       push;

  // Not full means not full: push while full cannot happen, even alongside a pop.
  assign ready      = alive_reg && (fifo_cnt_reg != 2'd2);
  assign push       = valid && ready;
  assign start      = (state_reg == IDLE) && (fifo_cnt_reg != 2'd0);
  assign start_rs   = fifo_mem[rd_ptr_reg][8];
  assign start_data = fifo_mem[rd_ptr_reg][7:0];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {rs, data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fifo_cnt_reg <= 2'd0;
      alive_reg    <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
      if (push)  wr_ptr_reg <= ~wr_ptr_reg;
      if (start) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, start})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end
`else
  logic ready_reg;

  assign ready      = ready_reg;
  assign start      = valid && ready_reg;
  assign start_rs   = rs;
  assign start_data = data;

  // Ready drops right after an accept and returns one clock after the post wait ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_reg <= 1'b0;
    else        ready_reg <= (state_reg == IDLE) && !start;
  end
`endif

  assign init_done = init_done_reg;
  assign lcd_e     = lcd_e_reg;
  assign lcd_rs    = lcd_rs_reg;
  assign lcd_data  = lcd_data_reg;
  assign lcd_rw    = 1'b0;
  assign sf_ce0    = 1'b1;

endmodule
